// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size encodings, state type and defaults for the load/store unit
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE    = 2'b00;
   localparam logic [1:0] SZ_HALF    = 2'b01;
   localparam logic [1:0] SZ_WORD    = 2'b10;
   localparam logic [1:0] SZ_ILLEGAL = 2'b11;

   localparam int DEFAULT_MEM_WORDS = 1024;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_RESP
   } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - little-endian lane extraction for loads and lane merging for stores
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] rd_word,
   input  logic [31:0] wdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lo,
                                                input logic [1:0] sz, input logic uns);
      logic [31:0] sh;
      logic [15:0] hw;
      sh = word >> {lo, 3'b000};
      hw = lo[1] ? word[31:16] : word[15:0];
      case (sz)
         SZ_BYTE: return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
         SZ_HALF: return uns ? {16'h0, hw} : {{16{hw[15]}}, hw};
         default: return word;
      endcase
   endfunction

   // Only the addressed lane is replaced; everything else comes from the word just read.
   function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [1:0] lo, input logic [1:0] sz);
      logic [4:0] sa;
      case (sz)
         SZ_BYTE: begin
            sa = {lo, 3'b000};
            return (old & ~(32'h0000_00FF << sa)) | ({24'h0, wd[7:0]} << sa);
         end
         SZ_HALF: begin
            sa = {lo[1], 4'b0000};
            return (old & ~(32'h0000_FFFF << sa)) | ({16'h0, wd[15:0]} << sa);
         end
         default: return wd;
      endcase
   endfunction

   assign load_data = load_extract(rd_word, addr_lo, size, is_unsigned);
   assign merged    = store_merge(rd_word, wdata, addr_lo, size);

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store sequencer between execute stage and word-addressed data memory
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = DEFAULT_MEM_WORDS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_A,
   output logic [31:0] mem_WD,
   output logic        mem_WE,
   input  logic [31:0] mem_RD
);

   lsu_state_t  state;
   logic        we_q;
   logic        uns_q;
   logic [1:0]  size_q;
   logic [1:0]  lo_q;
   logic [31:0] wdata_q;
   logic [31:0] load_data;
   logic [31:0] merged;
   logic        req_err;

   always_comb begin
      req_err = 1'b0;
      if (req_size == SZ_ILLEGAL)
         req_err = 1'b1;
      else if (req_size == SZ_HALF && req_addr[0])
         req_err = 1'b1;
      else if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
         req_err = 1'b1;
      else if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS))
         req_err = 1'b1;
   end

   lsu_lane_align u_align (
      .rd_word     (mem_RD),
      .wdata       (wdata_q),
      .addr_lo     (lo_q),
      .size        (size_q),
      .is_unsigned (uns_q),
      .load_data   (load_data),
      .merged      (merged)
   );

   // Outputs are registered alongside the state; the async reset clears mem_WE at once,
   // so a WRITE caught by reset never reaches the memory.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         mem_A     <= '0;
         mem_WD    <= '0;
         mem_WE    <= 1'b0;
         we_q      <= 1'b0;
         uns_q     <= 1'b0;
         size_q    <= SZ_BYTE;
         lo_q      <= 2'b00;
         wdata_q   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               if (req_valid && req_ready) begin
                  we_q      <= req_we;
                  size_q    <= req_size;
                  uns_q     <= req_unsigned;
                  lo_q      <= req_addr[1:0];
                  wdata_q   <= req_wdata;
                  mem_A     <= {2'b00, req_addr[31:2]};
                  rsp_rdata <= '0;
                  req_ready <= 1'b0;
                  if (req_err) begin
                     state     <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end else if (req_we && req_size == SZ_WORD) begin
                     state  <= ST_WRITE;
                     mem_WE <= 1'b1;
                     mem_WD <= req_wdata;
                  end else begin
                     state <= ST_READ;
                  end
               end
            end
            ST_READ: begin
               if (we_q) begin
                  state  <= ST_WRITE;
                  mem_WE <= 1'b1;
                  mem_WD <= merged;
               end else begin
                  state     <= ST_RESP;
                  rsp_rdata <= load_data;
                  rsp_valid <= 1'b1;
               end
            end
            ST_WRITE: begin
               state     <= ST_RESP;
               mem_WE    <= 1'b0;
               mem_WD    <= '0;
               rsp_valid <= 1'b1;
            end
            ST_RESP: begin
               state     <= ST_IDLE;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               req_ready <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a behavioural memory model
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_A;
   logic [31:0] mem_WD;
   logic        mem_WE;
   logic [31:0] mem_RD;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] tb_mem  [0:1023];
   logic [31:0] ref_mem [0:1023];

   always #5 clk = ~clk;

   load_store_unit #(.MEM_WORDS(1024)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .mem_A        (mem_A),
      .mem_WD       (mem_WD),
      .mem_WE       (mem_WE),
      .mem_RD       (mem_RD)
   );

   always_comb mem_RD = (mem_A < 32'd1024) ? tb_mem[mem_A[9:0]] : 32'h0;

   always @(posedge clk)
      if (mem_WE && mem_A < 32'd1024) tb_mem[mem_A[9:0]] <= mem_WD;

   // Reference: byte-array view of memory, updated per request.
   task automatic model(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic err, output int lat, output int wes);
      int idx, b;
      logic [7:0]  bytes [4];
      logic [31:0] r;
      idx = int'(addr >> 2);
      b   = int'(addr % 4);
      err = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
            (size == 2'd2 && b != 0) || (idx >= 1024);
      rd = 32'h0; lat = 1; wes = 0;
      if (!err) begin
         for (int k = 0; k < 4; k++) bytes[k] = ref_mem[idx][8*k +: 8];
         if (!we) begin
            lat = 2;
            if (size == 2'd0) begin
               r = {24'h0, bytes[b]};
               if (!uns && r >= 128) r = r - 32'd256;
            end else if (size == 2'd1) begin
               r = {16'h0, bytes[b+1], bytes[b]};
               if (!uns && r >= 32768) r = r - 32'd65536;
            end else begin
               r = ref_mem[idx];
            end
            rd = r;
         end else begin
            wes = 1;
            lat = (size == 2'd2) ? 2 : 3;
            if (size == 2'd0) bytes[b] = wdata[7:0];
            else if (size == 2'd1) begin bytes[b] = wdata[7:0]; bytes[b+1] = wdata[15:8]; end
            else for (int k = 0; k < 4; k++) bytes[k] = wdata[8*k +: 8];
            ref_mem[idx] = {bytes[3], bytes[2], bytes[1], bytes[0]};
         end
      end
   endtask

   task automatic apply(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat, output int wes);
      int w;
      w = 0;
      @(negedge clk);
      while (!req_ready && w < 10) begin @(negedge clk); w++; end
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      lat = 0; wes = 0; rdata = 'x; err = 1'bx;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (mem_WE) wes++;
         if (rsp_valid && lat == 0) begin lat = c; rdata = rsp_rdata; err = rsp_err; end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_WORD;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (2) @(negedge clk);
      vectors += 7;
      if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", req_ready); end
      if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
      if (rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata); end
      if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", rsp_err); end
      if (mem_A !== 32'h0) begin miscompares++; $display("FAIL reset_mem_A got %h exp 0", mem_A); end
      if (mem_WD !== 32'h0) begin miscompares++; $display("FAIL reset_mem_WD got %h exp 0", mem_WD); end
      if (mem_WE !== 1'b0) begin miscompares++; $display("FAIL reset_mem_WE got %b exp 0", mem_WE); end
      reset = 1'b0;
   endtask

   task automatic test_load_word;
      logic [31:0] rd; logic er; int lat, wes;
      apply(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, rd, er, lat, wes);
      vectors += 4;
      if (rd !== 32'h7) begin miscompares++; $display("FAIL lw_rdata got %h exp 00000007", rd); end
      if (er !== 1'b0) begin miscompares++; $display("FAIL lw_err got %b exp 0", er); end
      if (lat !== 2) begin miscompares++; $display("FAIL lw_latency got %0d exp 2", lat); end
      if (wes !== 0) begin miscompares++; $display("FAIL lw_mem_we got %0d exp 0", wes); end
   endtask

   task automatic test_store_then_loads;
      logic [31:0] rd, erd; logic er, eer; int lat, wes, el, ew;
      logic [1:0]  sz [4]  = '{SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF};
      logic        un [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] ad [4]  = '{32'hB, 32'hB, 32'hA, 32'h8};
      logic [31:0] ex [4]  = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF};
      model(1'b1, SZ_WORD, 1'b0, 32'h8, 32'hDEAD_BEEF, erd, eer, el, ew);
      apply(1'b1, SZ_WORD, 1'b0, 32'h8, 32'hDEAD_BEEF, rd, er, lat, wes);
      vectors += 3;
      if (tb_mem[2] !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL sw_mem got %h exp deadbeef", tb_mem[2]); end
      if (lat !== 2) begin miscompares++; $display("FAIL sw_latency got %0d exp 2", lat); end
      if (wes !== 1) begin miscompares++; $display("FAIL sw_mem_we got %0d exp 1", wes); end
      for (int i = 0; i < 4; i++) begin
         apply(1'b0, sz[i], un[i], ad[i], 32'h0, rd, er, lat, wes);
         vectors += 2;
         if (rd !== ex[i]) begin miscompares++; $display("FAIL ext_load%0d got %h exp %h", i, rd, ex[i]); end
         if (lat !== 2) begin miscompares++; $display("FAIL ext_load%0d_latency got %0d exp 2", i, lat); end
      end
   endtask

   task automatic test_sub_word_store;
      logic [31:0] rd, erd; logic er, eer; int lat, wes, el, ew;
      model(1'b1, SZ_BYTE, 1'b0, 32'h9, 32'h11, erd, eer, el, ew);
      apply(1'b1, SZ_BYTE, 1'b0, 32'h9, 32'h11, rd, er, lat, wes);
      vectors += 4;
      if (tb_mem[2] !== 32'hDEAD_11EF) begin miscompares++; $display("FAIL sb_mem got %h exp dead11ef", tb_mem[2]); end
      if (wes !== 1) begin miscompares++; $display("FAIL sb_mem_we got %0d exp 1", wes); end
      if (lat !== 3) begin miscompares++; $display("FAIL sb_latency got %0d exp 3", lat); end
      if (rd !== 32'h0) begin miscompares++; $display("FAIL sb_rdata got %h exp 0", rd); end
   endtask

   task automatic test_errors;
      logic [31:0] rd; logic er; int lat, wes; logic diff;
      logic        wv [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [1:0]  sv [4] = '{SZ_HALF, SZ_WORD, SZ_ILLEGAL, SZ_WORD};
      logic [31:0] av [4] = '{32'h1, 32'h6, 32'h0, 32'h1000};
      for (int i = 0; i < 4; i++) begin
         apply(wv[i], sv[i], 1'b0, av[i], 32'hFFFF_FFFF, rd, er, lat, wes);
         diff = 1'b0;
         for (int k = 0; k < 4; k++) if (tb_mem[k] !== ref_mem[k]) diff = 1'b1;
         vectors += 5;
         if (er !== 1'b1) begin miscompares++; $display("FAIL err%0d_flag got %b exp 1", i, er); end
         if (lat !== 1) begin miscompares++; $display("FAIL err%0d_latency got %0d exp 1", i, lat); end
         if (wes !== 0) begin miscompares++; $display("FAIL err%0d_mem_we got %0d exp 0", i, wes); end
         if (rd !== 32'h0) begin miscompares++; $display("FAIL err%0d_rdata got %h exp 0", i, rd); end
         if (diff !== 1'b0) begin miscompares++; $display("FAIL err%0d_mem_changed got %b exp 0", i, diff); end
      end
   endtask

   task automatic test_reset_mid_write;
      logic seen; int w;
      w = 0;
      @(negedge clk);
      while (!req_ready && w < 10) begin @(negedge clk); w++; end
      req_valid = 1'b1; req_we = 1'b1; req_size = SZ_HALF; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0000_CAFE;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (mem_WE !== 1'b1) begin miscompares++; $display("FAIL rst_write_cycle_we got %b exp 1", mem_WE); end
      #1 reset = 1'b1;
      #1;
      vectors += 2;
      if (mem_WE !== 1'b0) begin miscompares++; $display("FAIL rst_we_drop got %b exp 0", mem_WE); end
      if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready_async got %b exp 1", req_ready); end
      seen = 1'b0;
      repeat (2) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
      reset = 1'b0;
      #1;
      vectors++;
      if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready_release got %b exp 1", req_ready); end
      repeat (3) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
      vectors += 2;
      if (seen !== 1'b0) begin miscompares++; $display("FAIL rst_no_response got %b exp 0", seen); end
      if (tb_mem[0] !== 32'h5) begin miscompares++; $display("FAIL rst_mem0 got %h exp 00000005", tb_mem[0]); end
   endtask

   task automatic test_back_to_back;
      int acc_edge[$];
      int rsp_cyc[$];
      logic [31:0] rsp_dat[$];
      logic acc; int n_acc, w;
      w = 0;
      @(negedge clk);
      while (!req_ready && w < 10) begin @(negedge clk); w++; end
      req_valid = 1'b1; req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = 32'h4;
      n_acc = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         acc = req_valid && req_ready;
         if (rsp_valid) begin rsp_cyc.push_back(cyc); rsp_dat.push_back(rsp_rdata); end
         @(posedge clk);
         if (acc) begin
            acc_edge.push_back(cyc); n_acc++;
            #1;
            if (n_acc == 1) req_addr = 32'h8;
            else req_valid = 1'b0;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      vectors += 2;
      if (acc_edge.size() !== 2) begin
         miscompares++; $display("FAIL b2b_accept_count got %0d exp 2", acc_edge.size());
      end else if (acc_edge[0] !== 0 || acc_edge[1] !== 3) begin
         miscompares++; $display("FAIL b2b_accept_edges got %0d,%0d exp 0,3", acc_edge[0], acc_edge[1]);
      end
      if (rsp_cyc.size() !== 2) begin
         miscompares++; $display("FAIL b2b_rsp_count got %0d exp 2", rsp_cyc.size());
      end else begin
         vectors += 2;
         if (rsp_cyc[0] !== 2 || rsp_cyc[1] !== 5) begin
            miscompares++; $display("FAIL b2b_rsp_cycles got %0d,%0d exp 2,5", rsp_cyc[0], rsp_cyc[1]);
         end
         if (rsp_dat[0] !== ref_mem[1] || rsp_dat[1] !== ref_mem[2]) begin
            miscompares++;
            $display("FAIL b2b_rsp_order got %h,%h exp %h,%h", rsp_dat[0], rsp_dat[1], ref_mem[1], ref_mem[2]);
         end
      end
   endtask

   task automatic test_random;
      logic [31:0] rd, erd, addr, wd; logic er, eer, we, uns; logic [1:0] sz;
      int lat, wes, el, ew, sel;
      for (int n = 0; n < 60; n++) begin
         sel = int'($urandom_range(0, 9));
         case (sel)
            0:       addr = 32'h1000 + $urandom_range(0, 15);
            1:       addr = $urandom;
            default: addr = $urandom_range(0, 63);
         endcase
         sel = int'($urandom_range(0, 9));
         sz  = (sel == 0) ? 2'd3 : 2'(sel % 3);
         we  = 1'($urandom); uns = 1'($urandom); wd = $urandom;
         model(we, sz, uns, addr, wd, erd, eer, el, ew);
         apply(we, sz, uns, addr, wd, rd, er, lat, wes);
         vectors += 4;
         if (rd !== erd) begin miscompares++; $display("FAIL rnd%0d_rdata got %h exp %h", n, rd, erd); end
         if (er !== eer) begin miscompares++; $display("FAIL rnd%0d_err got %b exp %b", n, er, eer); end
         if (lat !== el) begin miscompares++; $display("FAIL rnd%0d_latency got %0d exp %0d", n, lat, el); end
         if (wes !== ew) begin miscompares++; $display("FAIL rnd%0d_mem_we got %0d exp %0d", n, wes, ew); end
         if ((addr >> 2) < 32'd1024) begin
            vectors++;
            if (tb_mem[addr[11:2]] !== ref_mem[addr[11:2]]) begin
               miscompares++;
               $display("FAIL rnd%0d_mem got %h exp %h", n, tb_mem[addr[11:2]], ref_mem[addr[11:2]]);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin tb_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
      tb_mem[0] = 32'h5; tb_mem[1] = 32'h7; tb_mem[2] = 32'h9; tb_mem[3] = 32'hA;
      ref_mem[0] = 32'h5; ref_mem[1] = 32'h7; ref_mem[2] = 32'h9; ref_mem[3] = 32'hA;
      test_reset();
      test_load_word();
      test_store_then_loads();
      test_sub_word_store();
      test_errors();
      test_reset_mid_write();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store sequencer between the core's execute stage and the word-addressed `data_memory`. It accepts byte-addressed load/store requests of byte, halfword or word size over a valid/ready handshake. It converts each request into word-indexed memory accesses, performing read-modify-write for sub-word stores and lane extraction with sign or zero extension for loads. It returns a one-cycle response pulse, and flags misaligned or out-of-range accesses without touching memory.

## Interface
- `MEM_WORDS`, 1024: number of 32-bit words in the attached memory; word index ≥ `MEM_WORDS` is an error.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high exactly when state is IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  32  load result; 0 for stores and errors.
- `rsp_err`  out  1  valid with `rsp_valid`; misaligned, illegal size or out of range.
- `mem_A`  out  32  word index = `{2'b00, addr[31:2]}`.
- `mem_WD`  out  32  merged write word; 0 outside WRITE.
- `mem_WE`  out  1  high only in WRITE.
- `mem_RD`  in  32  combinational read data from memory (valid while `mem_WE`=0).

## Operation
- The FSM has four states: IDLE, READ, WRITE and RESP.
- **IDLE**
  - A request is accepted when `req_valid` and `req_ready` are both high; the unit latches we, size, unsigned, addr and wdata.
  - Error check, in priority order: size 11; half with addr[0]=1; word with addr[1:0]≠0; addr[31:2] ≥ `MEM_WORDS`. On error, go to RESP with err=1 and make no memory access.
  - Otherwise: a load or sub-word store goes to READ; a word store goes to WRITE.
- **READ**
  - `mem_WE`=0 and `mem_A`=index; `mem_RD` is captured at the edge.
  - For a load, extract the lane, extend it into the result register, then go to RESP.
  - For a sub-word store, merge wdata into the captured word, then go to WRITE.
- **WRITE**: `mem_WE`=1 and `mem_WD`=merged word (or wdata for a word store); the memory writes on this edge; go to RESP.
- **RESP**: `rsp_valid`=1 for one cycle, then go to IDLE. There is no response backpressure.
- Lanes are little-endian.
  - A byte lane b=addr[1:0] occupies bits [8b+7:8b].
  - A half lane h=addr[1] occupies bits [16h+15:16h].
  - A merge replaces only the addressed lane; all other bits come from the captured word.
- `mem_A` holds the latched index through READ, WRITE and RESP, and is 0 after reset.

## Timing
- Acceptance happens at edge E0; "after Ek" means the cycle following edge Ek.
  - Load: READ after E0; `rsp_valid` after E1.
  - Word store: WRITE after E0; memory written at E1; `rsp_valid` after E1.
  - Sub-word store: READ after E0, WRITE after E1, memory written at E2, `rsp_valid` after E2.
  - Error: `rsp_valid` after E0.
- Maximum throughput is one request every 3 cycles for loads and word stores, and every 4 for sub-word stores. `req_ready` is low in all non-IDLE cycles.
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mem_A`=0, `mem_WD`=0, `mem_WE`=0.
- Reset asserted mid-operation:
  - The state goes to IDLE immediately, without waiting for a clock edge.
  - `mem_WE` drops in the same cycle, so a pending WRITE is not performed.
  - No response is issued for the aborted request.
- `req_valid` is ignored while `reset` is high.
- `req_*` inputs may change freely after acceptance, because the unit uses only its latched copies.

## Structure
- Package `lsu_pkg` holds:
  - the size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - the state enum;
  - the default `MEM_WORDS`.
- Sub-module `lsu_lane_align` is purely combinational and contains two functions:
  - load extract/extend: inputs word, addr[1:0], size, unsigned;
  - store merge: inputs old word, wdata, addr[1:0], size.
- The FSM and registers live in `load_store_unit`.

## Test plan
- Bench preload is words 0..3 = 0x5, 0x7, 0x9, 0xA.
- lw 0x4: `rsp_rdata`=0x00000007, `rsp_valid` in the second cycle after acceptance, `mem_WE` never high.
- sw 0xDEADBEEF @0x8, then:
  - lb 0xB returns 0xFFFFFFDE;
  - lbu 0xB returns 0x000000DE;
  - lh 0xA returns 0xFFFFDEAD;
  - lhu 0x8 returns 0x0000BEEF.
- sb 0x11 @0x9 on word 0xDEADBEEF: word 2 becomes 0xDEAD11EF, `mem_WE` is high for exactly one cycle, and `rsp_valid` arrives 3 cycles after acceptance.
- Each of the following returns `rsp_err`=1 and `rsp_valid` in the cycle after acceptance, with no `mem_WE` and memory unchanged:
  - lh @0x1;
  - sw @0x6;
  - size 11;
  - lw @0x1000.
- sh 0xCAFE @0x0, with reset pulsed during the WRITE cycle: `mem_WE` falls within that cycle, word 0 stays 0x5, no `rsp_valid`, and `req_ready`=1 after release.
- `req_valid` held high with two back-to-back lw requests: the second request is accepted only on the IDLE cycle after the first RESP, and the responses arrive in order.
